iter_divider: RTL
=================

// Module: iter_divider
// PURPOSE
//  Multi-cycle restoring integer divider: the inverse of the wide combinational add/sub/mul datapath.
//  Takes dividend/divisor via valid/ready and returns quotient and remainder one bit per cycle.
//  Sits beside the arithmetic block and serves any unit needing 128-bit division without a huge comb path.
// PARAMETERS
//  WIDTH  128  operand, quotient and remainder width in bits (>=2)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      dividend/divisor valid
//  in_ready   out  1      divider can accept operands
//  dividend   in   WIDTH  numerator
//  divisor    in   WIDTH  denominator
//  out_valid  out  1      result valid, held until accepted
//  out_ready  in   1      consumer accepts result
//  quotient   out  WIDTH  result quotient
//  remainder  out  WIDTH  result remainder
//  div_zero   out  1      result came from divisor==0
// BEHAVIOUR
//  - Reset: state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0, counter=0.
//  - FSM states: IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: in_ready=1. in_valid&in_ready latches operands. divisor==0 -> DONE next cycle.
//    Otherwise -> BUSY, counter=WIDTH.
//  - BUSY: one restoring step per cycle on a (WIDTH+1)-bit partial remainder.
//    Shift in next dividend MSB; subtract divisor; keep the difference if non-negative; shift quotient bit in.
//    Decrement counter; counter reaching 0 -> DONE.
//  - DONE: out_valid=1; outputs stable until out_valid&out_ready, then -> IDLE.
//    in_ready=0 in BUSY and DONE. No result buffering; back-pressure stalls in DONE indefinitely.
//  - Latency: in handshake to out_valid = WIDTH+1 cycles; divide-by-zero = 1 cycle.
//    Throughput: one op per WIDTH+2 cycles with out_ready tied high.
//  - Divide-by-zero: quotient = all ones, remainder = dividend, div_zero=1. Otherwise div_zero=0.
//  - Dividend < divisor: quotient 0, remainder = dividend (normal path, full latency).
//  - Reset mid-BUSY or mid-DONE: operation discarded, all outputs return to reset values next cycle.
//  - in_valid while busy is ignored; the source holds its operands until in_ready.
// CONFIGURATION
//  ITER_DIVIDER_SIGNED_EN defined:
//  - adds port: is_signed  in  1  (sampled with operands).
//  - When is_signed=1, operands are two's complement: magnitudes are divided.
//  - Quotient is negated if the operand signs differ; remainder takes the dividend's sign (truncating division).
//  - MIN_INT / -1: quotient = MIN_INT (wraps), remainder 0, div_zero=0.
//  - Signed divide-by-zero: same as unsigned (quotient all ones, remainder = dividend as given).
//  - Sign fix-up happens in the DONE-entry cycle, so latency is unchanged.
//  Not defined: no is_signed port; all operands are unsigned.
// STRUCTURE
//  - Package iter_div_pkg: state enum {IDLE,BUSY,DONE}; DIV_W_DEFAULT=128; function abs_val(); function neg().
//  - Sub-module iter_div_step (combinational): input {part_rem, next_bit, divisor}, output {new_rem, q_bit}.
//    Instantiated once; the top holds the FSM, counter ($clog2(WIDTH+1) bits) and shift registers.
// TESTING
//  1 unsigned: dividend=100, divisor=7 -> quotient=14, remainder=2, out_valid at cycle WIDTH+1.
//  2 dividend=0, divisor=0 -> div_zero=1, quotient=all ones, remainder=0, out_valid 1 cycle after accept.
//  3 back-pressure: out_ready=0 for 10 cycles after result -> outputs stable, in_ready=0; then one accept -> IDLE.
//  4 rst pulsed mid-BUSY (cycle 40): next cycle out_valid=0, in_ready=1; new op 2^127/3 -> correct result.
//  5 SIGNED_EN, is_signed=1: -7/2 -> quotient=-3, remainder=-1; MIN_INT/-1 -> quotient=MIN_INT, remainder=0.
//  6 random 10k ops vs reference model (/,%); includes dividend<divisor and divisor=1 -> exact match.

Source files
------------

// File: rtl/iter_div_pkg.sv
// Shared types and helpers for the iterative divider.
//   div_state_e   : control FSM states (IDLE -> BUSY -> DONE -> IDLE)
//   DIV_W_DEFAULT : default operand width
//   div_word_t    : wide carrier word used by the sign helpers so they work for any
//                   WIDTH <= DIV_W_MAX (callers zero-extend in and truncate out)
//   neg()/abs_val(): two's-complement negate and conditional magnitude
package iter_div_pkg;

  localparam int unsigned DIV_W_DEFAULT = 128;
  localparam int unsigned DIV_W_MAX     = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  typedef logic [DIV_W_MAX-1:0] div_word_t;

  // Low bits of the result are correct for any narrower two's-complement width.
  function automatic div_word_t neg(div_word_t v);
    return ~v + div_word_t'(1);
  endfunction

  function automatic div_word_t abs_val(div_word_t v, logic is_neg);
    return is_neg ? neg(v) : v;
  endfunction

endpackage

// File: rtl/iter_divider_if.sv
// Operand/result handshake bundle for iter_divider.
//   slave  modport : the divider (accepts operands, presents results)
//   master modport : the requester (drives operands, consumes results)
//   Signals: in_valid/in_ready/dividend/divisor, out_valid/out_ready/quotient/
//            remainder/div_zero; is_signed only when ITER_DIVIDER_SIGNED_EN is defined.
interface iter_divider_if #(
  parameter int unsigned WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef ITER_DIVIDER_SIGNED_EN
  logic             is_signed;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
`ifdef ITER_DIVIDER_SIGNED_EN
    input  is_signed,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output div_zero
  );

  modport master (
    output in_valid,
    output dividend,
    output divisor,
`ifdef ITER_DIVIDER_SIGNED_EN
    output is_signed,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  div_zero
  );
endinterface

// File: rtl/iter_div_step.sv
// One combinational restoring-division step.
//   part_rem : current partial remainder (always < divisor)
//   next_bit : next dividend bit, shifted into the partial remainder LSB
//   divisor  : divisor magnitude
//   new_rem  : partial remainder after the conditional subtract
//   q_bit    : quotient bit produced by this step
module iter_div_step #(
  parameter int unsigned WIDTH = 128
) (
  input  logic [WIDTH-1:0] part_rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_msbs;

  // Shifted value needs WIDTH+1 bits; one extra bit on the difference gives the borrow.
  assign shifted = {part_rem, next_bit};
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit   = ~diff[WIDTH+1];
  // Whichever value is kept is < divisor, so its top bit is always zero.
  assign new_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

  assign unused_msbs = diff[WIDTH] ^ shifted[WIDTH];

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring integer divider, one quotient bit per cycle.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : iter_divider_if.slave (operand handshake in, quotient/remainder/div_zero out)
// Optional feature: ITER_DIVIDER_SIGNED_EN adds bus.is_signed for truncating signed division.
// The dividend register doubles as the quotient register: dividend bits shift out of the
// MSB while quotient bits shift into the LSB.
module iter_divider
  import iter_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  iter_divider_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_fin;

`ifdef ITER_DIVIDER_SIGNED_EN
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;
  logic dvd_neg, dsr_neg;

  assign dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign dsr_neg = bus.is_signed & bus.divisor[WIDTH-1];
  assign dvd_mag = WIDTH'(abs_val(div_word_t'(bus.dividend), dvd_neg));
  assign dsr_mag = WIDTH'(abs_val(div_word_t'(bus.divisor), dsr_neg));
`else
  assign dvd_mag = bus.dividend;
  assign dsr_mag = bus.divisor;
`endif

  iter_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .part_rem (rem_q),
    .next_bit (acc_q[WIDTH-1]),
    .divisor  (dsr_q),
    .new_rem  (step_rem),
    .q_bit    (step_q)
  );

  assign q_fin = {acc_q[WIDTH-2:0], step_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    dsr_d      = dsr_q;
    div_zero_d = div_zero_q;
`ifdef ITER_DIVIDER_SIGNED_EN
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.divisor == '0) begin
            // Result is known immediately: all-ones quotient, dividend passed through raw.
            acc_d      = '1;
            rem_d      = bus.dividend;
            div_zero_d = 1'b1;
            state_d    = DONE;
`ifdef ITER_DIVIDER_SIGNED_EN
            neg_q_d    = 1'b0;
            neg_r_d    = 1'b0;
`endif
          end else begin
            acc_d      = dvd_mag;
            dsr_d      = dsr_mag;
            rem_d      = '0;
            div_zero_d = 1'b0;
            cnt_d      = CNT_W'(WIDTH);
            state_d    = BUSY;
`ifdef ITER_DIVIDER_SIGNED_EN
            neg_q_d    = dvd_neg ^ dsr_neg;
            neg_r_d    = dvd_neg;
`endif
          end
        end
      end
      BUSY: begin
        acc_d = q_fin;
        rem_d = step_rem;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
`ifdef ITER_DIVIDER_SIGNED_EN
          // Sign fix-up folded into the last step so latency matches the unsigned path.
          if (neg_q_q) acc_d = WIDTH'(neg(div_word_t'(q_fin)));
          if (neg_r_q) rem_d = WIDTH'(neg(div_word_t'(step_rem)));
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      dsr_q      <= '0;
      div_zero_q <= 1'b0;
`ifdef ITER_DIVIDER_SIGNED_EN
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      dsr_q      <= dsr_d;
      div_zero_q <= div_zero_d;
`ifdef ITER_DIVIDER_SIGNED_EN
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = acc_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = div_zero_q;

endmodule
